// File: rtl/constants_pkg.sv
// Shared constants and types for the PD4 front end.
// fetch_entry_t is the {pc, insn} pair buffered between fetch and decode.
package constants_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] PC_RESET_ADDR = 32'h0100_0000;

  localparam int FETCH_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] insn;
  } fetch_entry_t;

  // Credit test for the fetch request rule: slots already owed (buffered plus
  // in flight, less the entry leaving this cycle) must stay below the depth.
  function automatic logic fetch_credit_ok(input logic [1:0] count,
                                           input logic       inflight,
                                           input logic       pop);
    logic [2:0] used;
    used = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    return used < 3'(FETCH_FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of fetch entries with flush and a registered head.
// Flush has priority over push and pop; reset is asynchronous active-high.
module fetch_fifo
  import constants_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     wdata,
  output entry_t     head,
  output logic [1:0] count
);

  localparam int PW = $clog2(FETCH_FIFO_DEPTH);

  entry_t          mem [FETCH_FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [1:0]      count_q;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == 2'(FETCH_FIFO_DEPTH));
  assign empty   = (count_q == 2'd0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is read straight out of the storage flops, never from wdata.
  assign head  = mem[rd_ptr];
  assign count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FETCH_FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // The upstream credit scheme never lets a response arrive at a full buffer.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !flush));

endmodule

// File: rtl/fetch.sv
// PD4 instruction fetch: PC, credit-based imem requests, epoch-tagged responses
// and a 2-entry {pc, insn} buffer to decode. FETCH_PERF_CNT_EN adds perf counters.
module fetch
  import constants_pkg::*;
#(
  parameter int                DWIDTH   = DATA_WIDTH,
  parameter int                AWIDTH   = ADDR_WIDTH,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(PC_RESET_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [31:0]       fetched_cnt_o,
  output logic [31:0]       bubble_cnt_o
);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } fe_t;

  // Handshake: a transfer to decode happens in a cycle where valid_o and
  // ready_i are both high and redirect_i is low; valid_o never depends on
  // ready_i, and pc_o/insn_o hold steady while valid_o is high and not taken.

  logic [AWIDTH-1:0] pc_q;
  logic [AWIDTH-1:0] req_pc_q;
  logic              inflight_q;
  logic              inflight_epoch_q;
  logic              epoch_q;

  logic [1:0]        count;
  fe_t               head;
  fe_t               wentry;
  logic              hs;
  logic              pop;
  logic              push;
  logic              req;

  assign valid_o = (count != 2'd0);
  assign hs      = valid_o & ready_i;
  assign pop     = hs & ~redirect_i;

  // The raw handshake frees a slot for the credit test; in a redirect cycle
  // the request is suppressed anyway, so this cannot over-issue.
  assign req  = ~rst & ~redirect_i & fetch_credit_ok(count, inflight_q, hs);
  assign push = inflight_q & (inflight_epoch_q == epoch_q);

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;

  assign wentry = {req_pc_q, imem_rdata_i};
  assign pc_o   = head.pc;
  assign insn_o = head.insn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      req_pc_q         <= '0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else begin
      inflight_q <= req;
      if (req) begin
        inflight_epoch_q <= epoch_q;
        req_pc_q         <= pc_q;
      end
      if (redirect_i) begin
        epoch_q <= ~epoch_q;
        pc_q    <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
      end else if (req) begin
        pc_q <= pc_q + AWIDTH'(4);
      end
    end
  end

  fetch_fifo #(
    .entry_t (fe_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata (wentry),
    .head  (head),
    .count (count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] bubble_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      bubble_q  <= '0;
    end else begin
      if (pop) fetched_q <= fetched_q + 32'd1;
      if (ready_i & ~valid_o & ~redirect_i) bubble_q <= bubble_q + 32'd1;
    end
  end

  assign fetched_cnt_o = fetched_q;
  assign bubble_cnt_o  = bubble_q;
`else
  assign fetched_cnt_o = '0;
  assign bubble_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: reset/stream, counters, back-to-back redirect in a
// stall, buffered stall, redirect over an in-flight word, PC wrap, async reset.
module tb_fetch;
  import constants_pkg::*;

  localparam logic [31:0] KEY  = 32'hA5A5_0000;
  localparam logic [31:0] RPC  = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic [31:0] fetched_cnt_o;
  logic [31:0] bubble_cnt_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rdata_q = '0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  // Instruction memory: one-cycle latency, word = address ^ KEY.
  always @(posedge clk) if (imem_req_o) rdata_q <= imem_addr_o ^ KEY;
  assign imem_rdata_i = rdata_q;

  fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .insn_o        (insn_o),
    .fetched_cnt_o (fetched_cnt_o),
    .bubble_cnt_o  (bubble_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard load: the program-order PC stream starting at base.
  task automatic load_stream(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Driver: one clock cycle. Inputs change at the falling edge; outputs are
  // sampled 1 time unit later, and any transfer is scored against exp_q.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic [31:0] e;
    @(negedge clk);
    ready_i       = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    if (redir) load_stream({rpc[31:2], 2'b00});
    #1;
    if (valid_o && ready_i && !redirect_i) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check("xfer_pc", pc_o, e);
      check("xfer_insn", insn_o, e ^ KEY);
    end
  endtask

  initial begin
    logic [31:0] exp_f;
    logic [31:0] exp_b;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_valid", valid_o, 0);
    check("rst_req", imem_req_o, 0);
    check("rst_pc_o", pc_o, 0);
    check("rst_insn_o", insn_o, 0);
    check("rst_fetched", fetched_cnt_o, 0);
    check("rst_bubble", bubble_cnt_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    load_stream(RPC);

    // ---- stream after reset (c0..c6) ----
    cycle(1, 0, 0);
    check("c0_req", imem_req_o, 1);
    check("c0_addr", imem_addr_o, RPC);
    check("c0_valid", valid_o, 0);
    cycle(1, 0, 0);
    check("c1_valid", valid_o, 0);
    check("c1_addr", imem_addr_o, RPC + 32'd4);
    cycle(1, 0, 0);
    check("c2_valid", valid_o, 1);
    check("c2_pc", pc_o, RPC);
    repeat (4) cycle(1, 0, 0);

    // ---- back-to-back redirects, first one during a stall (c7, c8) ----
    cycle(0, 1, 32'h0100_0040);
    check("r1_req", imem_req_o, 0);
    check("r1_valid", valid_o, 1);
    cycle(1, 1, 32'h0100_0080);
    check("r2_req", imem_req_o, 0);
    check("r2_valid", valid_o, 0);
    cycle(1, 0, 0);
    check("r2p1_req", imem_req_o, 1);
    check("r2p1_addr", imem_addr_o, 32'h0100_0080);
    check("r2p1_valid", valid_o, 0);
    cycle(0, 0, 0);
    check("r2p2_valid", valid_o, 0);
    cycle(1, 0, 0);
    check("r2p3_valid", valid_o, 1);
    check("r2p3_pc", pc_o, 32'h0100_0080);
    repeat (4) cycle(1, 0, 0);

    // ---- 5-cycle stall; also the counter checkpoint ----
`ifdef FETCH_PERF_CNT_EN
    exp_f = 32'd10;
    exp_b = 32'd3;
`else
    exp_f = 32'd0;
    exp_b = 32'd0;
`endif
    for (int s = 0; s < 5; s++) begin
      cycle(0, 0, 0);
      check("stall_req", imem_req_o, 0);
      check("stall_valid", valid_o, 1);
      check("stall_pc", pc_o, 32'h0100_0094);
      if (s == 0) begin
        check("cnt_fetched", fetched_cnt_o, exp_f);
        check("cnt_bubble", bubble_cnt_o, exp_b);
      end
    end
    cycle(1, 0, 0);
    check("release_req", imem_req_o, 1);
    check("release_addr", imem_addr_o, 32'h0100_009C);
    repeat (6) cycle(1, 0, 0);

    // ---- redirect over an in-flight response, void handshake ----
    cycle(1, 1, 32'h0100_0203);
    check("rf_req", imem_req_o, 0);
    cycle(1, 0, 0);
    check("rf1_addr", imem_addr_o, 32'h0100_0200);
    check("rf1_req", imem_req_o, 1);
    check("rf1_valid", valid_o, 0);
    cycle(1, 0, 0);
    check("rf2_valid", valid_o, 0);
    cycle(1, 0, 0);
    check("rf3_valid", valid_o, 1);
    check("rf3_pc", pc_o, 32'h0100_0200);
    repeat (3) cycle(1, 0, 0);

    // ---- PC wrap ----
    cycle(1, 1, 32'hFFFF_FFFC);
    cycle(1, 0, 0);
    check("wrap1_addr", imem_addr_o, 32'hFFFF_FFFC);
    cycle(1, 0, 0);
    check("wrap2_addr", imem_addr_o, 32'h0000_0000);
    cycle(1, 0, 0);
    check("wrap3_pc", pc_o, 32'hFFFF_FFFC);
    repeat (3) cycle(1, 0, 0);

    // ---- asynchronous reset mid-cycle, then restart ----
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_req", imem_req_o, 0);
    check("arst_pc_o", pc_o, 0);
    check("arst_fetched", fetched_cnt_o, 0);
    check("arst_bubble", bubble_cnt_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    load_stream(RPC);
    cycle(1, 0, 0);
    check("re_c0_addr", imem_addr_o, RPC);
    check("re_c0_req", imem_req_o, 1);
    cycle(1, 0, 0);
    check("re_c1_valid", valid_o, 0);
    cycle(1, 0, 0);
    check("re_c2_valid", valid_o, 1);
    check("re_c2_pc", pc_o, RPC);
    repeat (3) cycle(1, 0, 0);
    cycle(0, 0, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage of the PD4 pipeline, directly upstream of `decode`. It owns the PC register and issues word reads to instruction memory, which has a fixed 1-cycle read latency. Returned words are buffered in a 2-entry FIFO and presented to decode as {pc, insn} pairs over a valid/ready handshake. It also handles control-flow redirects from execute, flushing wrong-path words.

## Interface
Parameters:
- `DWIDTH`, default `DATA_WIDTH` (32): instruction width.
- `AWIDTH`, default `ADDR_WIDTH` (32): PC / address width.
- `RESET_PC`, default `PC_RESET_ADDR` (32'h0100_0000): first fetch address.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req_o`  out  1  read request this cycle.
- `imem_addr_o`  out  AWIDTH  word address of the request; [1:0] always 0.
- `imem_rdata_i`  in  DWIDTH  read data, valid the cycle after a request.
- `redirect_i`  in  1  taken branch/jump from execute.
- `redirect_pc_i`  in  AWIDTH  redirect target.
- `ready_i`  in  1  decode accepts this cycle (low = stall).
- `valid_o`  out  1  `pc_o` and `insn_o` hold a valid instruction.
- `pc_o`  out  AWIDTH  PC of the presented instruction.
- `insn_o`  out  DWIDTH  presented instruction.
- `fetched_cnt_o`  out  32  instructions delivered (see Configuration).
- `bubble_cnt_o`  out  32  cycles with `ready_i`=1 and `valid_o`=0.

## Operation
- **State:**
  - `pc_q`: next fetch address.
  - `inflight_q`: a response is due next cycle.
  - `epoch_q`: 1-bit tag on each in-flight request.
  - FIFO of {pc, insn}, depth 2, `count` 0..2.
- **Request rule:** `imem_req_o` = !`rst` & !`redirect_i` & (`count` + `inflight_q` − `pop` < 2), where `pop` = `valid_o` & `ready_i`.
  - On a request: `pc_q` ← `pc_q` + 4, modulo 2^AWIDTH (wraps to 0).
  - `imem_addr_o` = `pc_q`.
- **Response:** the cycle after a request, {address, `imem_rdata_i`} is pushed into the FIFO, unless its epoch differs from `epoch_q` (it is dropped).
  - A push into a full FIFO cannot occur under the request rule. It is an assertion failure.
- **Output:** `valid_o` = (`count` ≠ 0). `pc_o` and `insn_o` come from the FIFO head, registered, not bypassed from `imem_rdata_i`.
  - Push and pop in the same cycle are both legal and leave `count` unchanged.
- **Redirect** (priority over push, pop and request):
  - FIFO is flushed (`count` ← 0).
  - `epoch_q` is toggled, so any in-flight response is dropped.
  - `pc_q` ← {`redirect_pc_i`[AWIDTH-1:2], 2'b00}; the low bits are silently cleared.
  - The handshake in the redirect cycle is void. Decode must not treat a `valid_o` & `ready_i` in that cycle as a transfer, and the counters do not count it.
  - Back-to-back redirects: the last one wins.
- **Stall** (`ready_i`=0): FIFO contents hold. Requests continue only while credit remains, so at most 2 words are buffered and no data is lost.
- **Reset:**
  - `pc_q` = `RESET_PC`; `count`, `inflight_q`, `epoch_q` and both counters = 0.
  - Outputs: `valid_o`=0, `imem_req_o`=0, `pc_o`=0, `insn_o`=0.
  - Reset asserted mid-operation discards everything immediately (asynchronous); an in-flight response is ignored.

## Timing
- Reset deasserted before cycle 0:
  - Cycle 0: req, addr `RESET_PC`.
  - Cycle 1: data returns.
  - Cycle 2: `valid_o`=1, `pc_o`=`RESET_PC`.
- Fetch-to-decode latency is 2 cycles. Steady-state throughput is 1 instruction/cycle with `ready_i` held high.
- Redirect in cycle R:
  - R: no request.
  - R+1: req to target.
  - R+3: `valid_o`=1 with the target PC.
  - `valid_o`=0 in R+1 and R+2.
- `ready_i` falling in cycle S: at most one further request issues (in S, if credit allows). The FIFO is full by S+2. Requests resume the cycle `ready_i` returns high with a pop.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetched_cnt_o` increments on each pop (excluding redirect cycles).
  - `bubble_cnt_o` increments on each cycle with `ready_i`=1 & `valid_o`=0 & !`redirect_i`.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops exist.

## Structure
- `constants_pkg` gets:
  - `PC_RESET_ADDR`.
  - `fetch_entry_t` (packed {pc[AWIDTH-1:0], insn[DWIDTH-1:0]}).
  - `FETCH_FIFO_DEPTH` = 2.
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO of `fetch_entry_t` with push, pop, flush, count, and registered head. Asynchronous active-high reset. Flush has priority over push.
- The top level holds the PC, credit/epoch logic and counters.

## Test plan
- **Reset and stream:** `ready_i`=1, memory returns addr^32'hA5A5_0000.
  - First `valid_o` in cycle 2 with `pc_o`=32'h0100_0000.
  - Then one instruction per cycle at +4 PCs, with `insn_o` matching.
- **Stall:** drop `ready_i` for 5 cycles mid-stream.
  - At most 2 entries buffered; `imem_req_o` low once credit is exhausted.
  - On release, PCs continue contiguously with no loss or duplicate.
- **Redirect with in-flight response:** redirect to 32'h0100_0203 while a request is pending.
  - Pending word dropped, FIFO flushed.
  - `imem_addr_o`=32'h0100_0200 in R+1; `valid_o` with that PC in R+3.
- **Redirect during stall and back-to-back:** redirects in consecutive cycles to 0x0100_0040 then 0x0100_0080.
  - Only 0x0100_0080 is fetched; `valid_o`=0 in R+1 and R+2.
- **Wrap and async reset:**
  - Redirect to 32'hFFFF_FFFC: next fetch address is 0.
  - Assert `rst` mid-cycle: `valid_o`=0 and `imem_req_o`=0 immediately; restart from `RESET_PC`.
- **Counters** (with `FETCH_PERF_CNT_EN`): 10 delivered instructions plus 3 bubble cycles give `fetched_cnt_o`=10 and `bubble_cnt_o`=3. Without the macro, both read 0.
